// File: rtl/jtsbaskt_sndcmd.sv
// Sound command transmitter: queues main CPU writes, loads the sound latch one byte
// at a time and raises the sound IRQ. Optional macro JTSBASKT_SNDCMD_TIMEOUT_EN adds a WAIT_RD timeout.
module jtsbaskt_sndcmd #(
  parameter int AW   = 2,
  parameter int IRQW = 4,
  parameter int TOUT = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       snd_cen,
  input  logic       cmd_we,
  input  logic [7:0] cmd_din,
  input  logic       latch_rd,
  output logic [7:0] snd_dout,
  output logic       m2s_data,
  output logic       m2s_on,
  output logic       fifo_full,
  output logic       busy,
  output logic       drop
);

  typedef enum logic [1:0] {IDLE, LOAD, IRQ, WAIT_RD} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [2**AW];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, push, pop;
  logic          latch_rd_l, rd_edge, rd_seen;
  logic [3:0]    irq_cnt;

  assign empty     = (wr_ptr == rd_ptr);
  assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push      = cmd_we & ~fifo_full;
  assign pop       = (state == LOAD);
  assign rd_edge   = latch_rd & ~latch_rd_l;
  assign m2s_data  = (state == LOAD);
  assign busy      = ~empty | (state != IDLE);

  // NOTE: storage has no reset; emptiness comes from the pointers, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= cmd_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      drop   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      drop <= cmd_we & fifo_full;
    end
  end

`ifdef JTSBASKT_SNDCMD_TIMEOUT_EN
  localparam int TW = $clog2(TOUT + 1);
  logic [TW-1:0] to_cnt;
  logic          to_hit;

  assign to_hit = snd_cen && (to_cnt == TW'(TOUT - 1));

  // Runs only while waiting for the read, so it restarts on every WAIT_RD entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  to_cnt <= '0;
    else if (state != WAIT_RD)   to_cnt <= '0;
    else if (snd_cen)            to_cnt <= to_cnt + 1'b1;
  end
`endif

  always_comb begin
    // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = LOAD;
      LOAD:    state_nxt = IRQ;
      IRQ:     if (snd_cen && irq_cnt == 4'(IRQW - 1)) state_nxt = WAIT_RD;
      WAIT_RD: begin
        if (rd_edge || rd_seen) state_nxt = IDLE;
`ifdef JTSBASKT_SNDCMD_TIMEOUT_EN
        else if (to_hit)        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      snd_dout   <= 8'h00;
      m2s_on     <= 1'b0;
      irq_cnt    <= 4'd0;
      latch_rd_l <= 1'b0;
      rd_seen    <= 1'b0;
    end else begin
      state      <= state_nxt;
      latch_rd_l <= latch_rd;
      m2s_on     <= (state_nxt == IRQ);
      // Latch is valid during the LOAD cycle so the m2s_data strobe sees the new byte
      if (state == IDLE && !empty) snd_dout <= mem[rd_ptr[AW-1:0]];
      if (state == IRQ) begin
        if (snd_cen) irq_cnt <= irq_cnt + 1'b1;
      end else begin
        irq_cnt <= 4'd0;
      end
      // A read that arrives while the IRQ is still high is remembered for WAIT_RD
      case (state)
        IRQ:     rd_seen <= rd_seen | rd_edge;
        WAIT_RD: rd_seen <= rd_seen;
        default: rd_seen <= 1'b0;
      endcase
    end
  end

endmodule
